mips_instr_loader: RTL and testbench
====================================

Name: mips_instr_loader

Overview:
- Receive side of the debug UART link: deserializes bytes from the UART receiver into 32-bit instruction words and writes them into MIPS instruction memory.
- Sits between the UART RX and the instruction-memory write port. The debug unit triggers it with a start pulse when the 'l' command arrives.
- Byte order is MSB-first, the same order the debug unit uses when it serializes words for TX.
- Loading ends on a terminator word, on memory overflow, or on an inter-byte timeout.

Parameters:
- DATA_BITS, 8, UART byte width.
- NBITS, 32, instruction word width; must be a multiple of DATA_BITS.
- IMEM_ADDR_BITS, 8, word-address width; memory depth = 2**IMEM_ADDR_BITS.
- END_WORD, 32'hFFFFFFFF, terminator word (the HALT encoding); it is written to memory, then loading completes.
- TIMEOUT_CYCLES, 1000000, maximum clk cycles between bytes while receiving; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- i_load_start  in  1  one-cycle start pulse from the debug unit
- i_uart_rx_ready  in  1  a received byte is available
- i_uart_rx_data  in  DATA_BITS  received byte
- o_uart_rx_reset  out  1  byte acknowledge/clear to the UART RX
- o_imem_we  out  1  instruction-memory write enable
- o_imem_addr  out  IMEM_ADDR_BITS  word write address
- o_imem_data  out  NBITS  word write data
- o_busy  out  1  high while loading
- o_done  out  1  one-cycle pulse on successful completion
- o_error  out  1  sticky error flag
- o_word_count  out  IMEM_ADDR_BITS+1  words written in the current or last load

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0 except o_uart_rx_reset=1.
  - Shift register, byte counter and timeout counter cleared; a partial word is discarded.
  - Reset mid-load leaves memory contents as already written.
- States: IDLE, RECV, WRITE, DONE, ERR.
- IDLE:
  - o_busy=0, o_uart_rx_reset held 1, so bytes are neither consumed nor buffered.
  - i_load_start=1 → RECV next cycle; clears address, byte counter, o_word_count and o_error.
- RECV: o_busy=1.
  - A byte is accepted in any cycle where i_uart_rx_ready=1 and o_uart_rx_reset=0:
    - shift <= {shift[NBITS-DATA_BITS-1:0], i_uart_rx_data}; byte counter +1; timeout counter cleared;
    - o_uart_rx_reset=1 for exactly the next cycle, then 0.
  - Accepting byte number NBITS/DATA_BITS (the 4th) → WRITE.
  - Timeout counter increments each RECV cycle with no accepted byte. Reaching TIMEOUT_CYCLES (when nonzero) → ERR.
- WRITE: single cycle.
  - o_imem_we=1, o_imem_addr=current address, o_imem_data=assembled word.
  - Latency: last byte accepted in cycle N → we=1 in cycle N+1.
  - Then address +1, o_word_count +1, byte counter cleared.
  - Next state, in priority order:
    - word==END_WORD → DONE;
    - else address was 2**IMEM_ADDR_BITS-1 (memory full, no terminator) → ERR;
    - else → RECV.
  - The terminator written into the last location still goes to DONE.
- DONE: o_done=1 for one cycle, o_busy=0 → IDLE.
- ERR: o_error=1 (sticky), o_busy=0 → IDLE.
  - o_error clears only on the next i_load_start or on reset.
- Outputs o_imem_addr and o_imem_data are registered and hold their values outside WRITE; o_imem_we is 0 outside WRITE.
- i_load_start while o_busy=1 is ignored.
- A byte is never accepted in the same cycle as a state change into RECV.
- Address counter width is IMEM_ADDR_BITS+1 internally so the full condition is detected without wrap-around.

Decomposition:
- Shared debug package holds:
  - UART command codes ('r','s','l','n');
  - END_WORD;
  - loader state encodings.
- Natural sub-module: mips_byte_deserializer (shift register, byte counter, rx_reset acknowledge, word_valid pulse). The FSM, address counter and timeout counter stay in the top.

Test Plan:
- Start, then bytes 20 08 00 05, 00 00 00 00, FF FF FF FF → writes 0x20080005@0, 0x00000000@1, 0xFFFFFFFF@2; o_done pulse; o_word_count=3; o_error=0.
- Byte arriving with i_uart_rx_ready held high → exactly one accept per byte, o_uart_rx_reset high one cycle after each accept, no duplicate shifts.
- IMEM_ADDR_BITS=2, stream 4 non-terminator words → writes @0..3, then o_error=1, no o_done, o_word_count=4.
- TIMEOUT_CYCLES=50, send 2 bytes then stop → after 50 idle cycles o_error=1, o_busy=0, no write; the next start clears o_error.
- Assert reset (0) after 2 bytes of word 1 → all outputs at reset values. A new load then writes its first word at address 0, built from fresh bytes only.
- Pulse i_load_start during RECV → ignored; address and byte count unchanged.

Source files
------------

// File: rtl/mips_instr_loader_pkg.sv
// Shared definitions for the debug UART link: command codes, the terminator word
// and the instruction-loader state encoding.
package mips_instr_loader_pkg;

    localparam logic [7:0] CMD_READ = 8'h72;  // 'r'
    localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
    localparam logic [7:0] CMD_LOAD = 8'h6c;  // 'l'
    localparam logic [7:0] CMD_NEXT = 8'h6e;  // 'n'

    localparam logic [31:0] DEFAULT_END_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRecv  = 3'd1,
        StWrite = 3'd2,
        StDone  = 3'd3,
        StErr   = 3'd4
    } loader_state_e;

endpackage

// File: rtl/mips_byte_deserializer.sv
// Collects UART bytes MSB-first into a word, acknowledging each accepted byte by
// raising rx_reset for one cycle.
module mips_byte_deserializer #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned NBITS     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_recv,
    input  logic                 i_recv_next,
    input  logic                 i_rx_ready,
    input  logic [DATA_BITS-1:0] i_rx_data,
    output logic                 o_rx_reset,
    output logic                 o_byte_accept,
    output logic                 o_word_valid,
    output logic [NBITS-1:0]     o_word
);

    localparam int unsigned NBYTES = NBITS / DATA_BITS;
    localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    logic [NBITS-1:0] shift_q, shift_d, shift_next;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rx_reset_q, rx_reset_d;
    logic             accept;

    assign accept        = i_recv & i_rx_ready & ~rx_reset_q;
    assign shift_next    = NBITS'({shift_q, i_rx_data});
    assign o_byte_accept = accept;
    assign o_word_valid  = accept && (cnt_q == LAST_BYTE);
    assign o_word        = shift_next;
    assign o_rx_reset    = rx_reset_q;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (i_clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (accept) begin
            shift_d = shift_next;
            cnt_d   = (cnt_q == LAST_BYTE) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Keep the UART cleared whenever the loader is not going to be receiving.
    always_comb begin
        rx_reset_d = accept | ~i_recv_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            rx_reset_q <= 1'b1;
        end else begin
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            rx_reset_q <= rx_reset_d;
        end
    end

endmodule

// File: rtl/mips_instr_loader.sv
// Loads instruction words received over the debug UART into instruction memory,
// stopping on the terminator word, memory overflow or inter-byte timeout.
module mips_instr_loader
    import mips_instr_loader_pkg::*;
#(
    parameter int unsigned      DATA_BITS      = 8,
    parameter int unsigned      NBITS          = 32,
    parameter int unsigned      IMEM_ADDR_BITS = 8,
    parameter logic [NBITS-1:0] END_WORD       = NBITS'(DEFAULT_END_WORD),
    parameter int unsigned      TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_load_start,
    input  logic                      i_uart_rx_ready,
    input  logic [DATA_BITS-1:0]      i_uart_rx_data,
    output logic                      o_uart_rx_reset,
    output logic                      o_imem_we,
    output logic [IMEM_ADDR_BITS-1:0] o_imem_addr,
    output logic [NBITS-1:0]          o_imem_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_error,
    output logic [IMEM_ADDR_BITS:0]   o_word_count
);

    localparam int unsigned TMO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TMO_LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LIMIT);
    localparam logic [IMEM_ADDR_BITS:0] LAST_ADDR = {1'b0, {IMEM_ADDR_BITS{1'b1}}};

    loader_state_e state_q, state_d;

    // One extra address bit so a full memory is seen without wrapping to zero.
    logic [IMEM_ADDR_BITS:0]   addr_q, addr_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic                      error_q, error_d;
    logic [IMEM_ADDR_BITS-1:0] imem_addr_q, imem_addr_d;
    logic [NBITS-1:0]          imem_data_q, imem_data_d;
    logic                      load_clear;
    logic                      byte_accept;
    logic                      word_valid;
    logic [NBITS-1:0]          word;

    mips_byte_deserializer #(
        .DATA_BITS (DATA_BITS),
        .NBITS     (NBITS)
    ) u_deser (
        .clk           (clk),
        .reset         (reset),
        .i_clear       (load_clear),
        .i_recv        (state_q == StRecv),
        .i_recv_next   (state_d == StRecv),
        .i_rx_ready    (i_uart_rx_ready),
        .i_rx_data     (i_uart_rx_data),
        .o_rx_reset    (o_uart_rx_reset),
        .o_byte_accept (byte_accept),
        .o_word_valid  (word_valid),
        .o_word        (word)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tmo_d       = '0;
        error_d     = error_q;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
        load_clear  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_load_start) begin
                    state_d    = StRecv;
                    addr_d     = '0;
                    error_d    = 1'b0;
                    load_clear = 1'b1;
                end
            end
            StRecv: begin
                if (word_valid) begin
                    state_d     = StWrite;
                    imem_addr_d = addr_q[IMEM_ADDR_BITS-1:0];
                    imem_data_d = word;
                end else if (!byte_accept) begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if ((TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST)) begin
                        state_d = StErr;
                    end
                end
            end
            StWrite: begin
                addr_d = addr_q + 1'b1;
                if (imem_data_q == END_WORD) begin
                    state_d = StDone;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = StErr;
                end else begin
                    state_d = StRecv;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (state_d == StErr) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            tmo_q       <= '0;
            error_q     <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            tmo_q       <= tmo_d;
            error_q     <= error_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
        end
    end

    assign o_imem_we    = (state_q == StWrite);
    assign o_imem_addr  = imem_addr_q;
    assign o_imem_data  = imem_data_q;
    assign o_busy       = (state_q == StRecv) || (state_q == StWrite);
    assign o_done       = (state_q == StDone);
    assign o_error      = error_q;
    assign o_word_count = addr_q;

endmodule

// File: tb/tb_mips_instr_loader.sv
// Self-checking bench for mips_instr_loader: directed scenarios plus randomized
// word streams compared against a list-level model of the load outcome.
module tb_mips_instr_loader;

    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 50;
    localparam logic [31:0] END   = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic          rx_ready;
    logic [7:0]    rx_data;
    logic          rx_rst;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   wcount;

    always #5 clk = ~clk;

    mips_instr_loader #(
        .DATA_BITS      (8),
        .NBITS          (32),
        .IMEM_ADDR_BITS (AW),
        .END_WORD       (END),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_load_start    (load_start),
        .i_uart_rx_ready (rx_ready),
        .i_uart_rx_data  (rx_data),
        .o_uart_rx_reset (rx_rst),
        .o_imem_we       (we),
        .o_imem_addr     (addr),
        .o_imem_data     (data),
        .o_busy          (busy),
        .o_done          (done),
        .o_error         (error),
        .o_word_count    (wcount)
    );

    int          checks   = 0;
    int          failures = 0;
    int          done_cnt = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] words[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic        exp_done;
    logic        exp_err;
    int          exp_cnt;

    always @(negedge clk) begin
        if (we) begin
            wr_addr.push_back(32'(addr));
            wr_data.push_back(data);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Outcome of a load, from the word list alone: word i lands at address i until
    // the terminator is written or the last location is filled.
    task automatic model();
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_cnt  = 0;
        for (int i = 0; i < words.size(); i++) begin
            exp_addr.push_back(32'(i));
            exp_data.push_back(words[i]);
            exp_cnt = i + 1;
            if (words[i] == END) begin
                exp_done = 1'b1;
                break;
            end
            if (i == DEPTH - 1) begin
                exp_err = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_load();
        wr_addr.delete();
        wr_data.delete();
        done_cnt   = 0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit hold);
        int t;
        cyc(gap);
        rx_ready = 1'b1;
        rx_data  = b;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rx_rst && t < 20);
        check("byte_ack", 64'(rx_rst), 64'd1);
        if (hold) begin
            // Byte still presented: ack must drop after one cycle and not re-accept.
            @(negedge clk);
            check("ack_one_cycle", 64'(rx_rst), 64'(!busy));
        end
        rx_ready = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap, input int hold_mode);
        logic [31:0] v;
        v = w;
        for (int b = 0; b < 4; b++) begin
            send_byte(v[31:24], int'($urandom_range(0, maxgap)),
                      (hold_mode == 2) ? bit'($urandom_range(0, 1)) : bit'(hold_mode));
            v = v << 8;
        end
    endtask

    task automatic finish_load();
        int t;
        t = 0;
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("load_ends", 64'(busy), 64'd0);
        cyc(2);
    endtask

    task automatic check_results(input string tag);
        check({tag, "_nwrites"}, 64'(wr_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
            check({tag, "_addr"}, 64'(wr_addr[i]), 64'(exp_addr[i]));
            check({tag, "_data"}, 64'(wr_data[i]), 64'(exp_data[i]));
        end
        check({tag, "_done"}, 64'(done_cnt), exp_done ? 64'd1 : 64'd0);
        check({tag, "_error"}, 64'(error), 64'(exp_err));
        check({tag, "_count"}, 64'(wcount), 64'(exp_cnt));
    endtask

    task automatic run_load(input string tag, input int maxgap, input int hold_mode);
        model();
        start_load();
        for (int i = 0; i < exp_cnt; i++) send_word(words[i], maxgap, hold_mode);
        finish_load();
        check_results(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_reset"}, 64'(rx_rst), 64'd1);
        check({tag, "_we"}, 64'(we), 64'd0);
        check({tag, "_addr"}, 64'(addr), 64'd0);
        check({tag, "_data"}, 64'(data), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_count"}, 64'(wcount), 64'd0);
    endtask

    initial begin
        int t;
        int n;
        logic [31:0] w;
        reset      = 1'b1;
        load_start = 1'b0;
        rx_ready   = 1'b0;
        rx_data    = '0;
        #3 reset = 1'b0;
        cyc(3);
        check_reset_outputs("reset");
        reset = 1'b1;
        cyc(2);

        // Idle: bytes are not consumed.
        rx_ready = 1'b1;
        rx_data  = 8'h55;
        cyc(3);
        check("idle_rx_reset", 64'(rx_rst), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);
        rx_ready = 1'b0;
        cyc(1);

        // Basic load with every byte held ready across its ack cycle.
        words = '{32'h2008_0005, 32'h0000_0000, END};
        run_load("basic", 0, 1);

        // Overflow: memory fills without a terminator.
        words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        run_load("overflow", 2, 0);

        // Timeout after two bytes; the start also clears the sticky error.
        start_load();
        check("start_clears_error", 64'(error), 64'd0);
        send_byte(8'h12, 0, 0);
        send_byte(8'h34, 0, 0);
        cyc(40);
        check("no_early_timeout", 64'(error), 64'd0);
        check("busy_before_timeout", 64'(busy), 64'd1);
        t = 0;
        while (!error && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("timeout_error", 64'(error), 64'd1);
        check("timeout_busy", 64'(busy), 64'd0);
        check("timeout_nwrites", 64'(wr_addr.size()), 64'd0);
        cyc(2);

        // Start pulse during RECV is ignored.
        words = '{32'hDEAD_BEEF, END};
        model();
        start_load();
        check("restart_clears_error", 64'(error), 64'd0);
        send_byte(8'hDE, 0, 0);
        send_byte(8'hAD, 1, 0);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("start_ignored_busy", 64'(busy), 64'd1);
        send_byte(8'hBE, 0, 0);
        send_byte(8'hEF, 0, 0);
        send_word(END, 1, 0);
        finish_load();
        check_results("ignore_start");

        // Reset mid-word discards the partial word.
        start_load();
        send_byte(8'hA1, 0, 0);
        send_byte(8'hB2, 0, 0);
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        reset = 1'b1;
        cyc(1);
        words = '{32'h0BAD_F00D, END};
        run_load("after_reset", 1, 0);

        // Randomized word streams, some ending in overflow.
        for (int it = 0; it < 10; it++) begin
            n = int'($urandom_range(0, DEPTH));
            words.delete();
            for (int i = 0; i < n; i++) begin
                w = $urandom();
                if (w == END) w = 32'h0;
                words.push_back(w);
            end
            if (n < DEPTH) words.push_back(END);
            run_load("random", 4, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
